hpi_access_seq: RTL and testbench
=================================

HPI_ACCESS_SEQ -- requirements
Module: hpi_access_seq

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 4: number of cycles hpi_r_n/hpi_w_n is held low; legal range 1..15.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2: number of cycles after the strobe with cs still asserted; legal range 1..15.
REQ-003 SHALL have parameter RECOVERY_CYCLES, default 1: number of cycles cs is deasserted between transactions; legal range 1..15.
REQ-004 SHALL have a single clock and a synchronous, active-high reset, with ports:
- Clk  in  1  single clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- req0, req1  in  1  requester n transaction request, level, held until ackn
- we0, we1  in  1  1=write, 0=read
- addr0, addr1  in  2  HPI register select
- wdata0, wdata1  in  16  write data
- ack0, ack1  out  1  one-cycle completion pulse
- rdata0, rdata1  out  16  read result
- hpi_address  out  2  to interface from_sw_address
- hpi_data_out  out  16  to interface from_sw_data_out
- hpi_data_in  in  16  from interface from_sw_data_in
- hpi_r_n, hpi_w_n, hpi_cs_n  out  1  active-low strobes to interface
- busy  out  1  high whenever state != IDLE

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, RECOVER.
REQ-006 SHALL sample requests only in IDLE; with exactly one req high, grant that requester.
REQ-007 SHALL grant the requester not granted last when req0 and req1 are both high in IDLE; the last-grant pointer resets to requester 1, so requester 0 wins the first tie.
REQ-008 SHALL latch the granted requester's we, addr and wdata on the grant edge and move IDLE->SETUP; later changes to requester inputs SHALL NOT affect the transaction in flight.
REQ-009 SETUP SHALL last 1 cycle: hpi_cs_n=0, hpi_address=latched addr, hpi_r_n=hpi_w_n=1.
REQ-010 STROBE SHALL last STROBE_CYCLES cycles: hpi_cs_n=0; hpi_w_n=0 for a write, hpi_r_n=0 for a read; never both low.
REQ-011 HOLD SHALL last HOLD_CYCLES cycles: hpi_cs_n=0, both strobes 1; for a read, hpi_data_in is captured on the clock edge that ends the last HOLD cycle.
REQ-012 On HOLD->RECOVER, SHALL pulse ack of the granted requester for exactly 1 cycle, which is the first RECOVER cycle; for a read, rdataN SHALL present the captured value in that same cycle.
REQ-013 rdataN SHALL hold its value until the next completed read for that requester; writes SHALL NOT change rdataN.
REQ-014 RECOVER SHALL last RECOVERY_CYCLES cycles with hpi_cs_n=1 and both strobes 1, then return to IDLE.
REQ-015 hpi_address and hpi_data_out SHALL hold the latched values from SETUP through the end of RECOVER, and SHALL keep them while IDLE.
REQ-016 Latency: with the req sampled in IDLE at cycle 0, ack SHALL be high at cycle 2+STROBE_CYCLES+HOLD_CYCLES; with defaults this is cycle 8.
REQ-017 The earliest next grant SHALL occur at cycle 2+STROBE_CYCLES+HOLD_CYCLES+RECOVERY_CYCLES; with defaults this is cycle 9.
REQ-018 A requester keeping req high in the cycle after its ack SHALL be treated as a new request at the next IDLE.
REQ-019 A req that drops before its grant SHALL be ignored; a req that drops after its grant SHALL NOT abort the transaction.
REQ-020 Phase counters SHALL be 4 bits wide, load the parameter minus 1 on phase entry, and advance phase at count 0; no wrap-around beyond one phase.
REQ-021 At most one ack SHALL be high in any cycle.

Reset
REQ-022 On Reset=1 at a clock edge, SHALL enter IDLE and drive: hpi_cs_n=hpi_r_n=hpi_w_n=1, hpi_address=0, hpi_data_out=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, last-grant pointer=1.
REQ-023 Reset asserted mid-transaction SHALL abort it: strobes inactive on the next edge, no ack issued, request not retried internally.
REQ-024 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-025 Single write: req0=1, we0=1, addr0=2, wdata0=16'h1234 -> hpi_cs_n low cycles 1-7, hpi_w_n low cycles 2-5, hpi_data_out=16'h1234, hpi_address=2, ack0 only at cycle 8.
REQ-026 Single read: req1=1, we1=0, addr1=0, hpi_data_in=16'hBEEF during HOLD -> hpi_r_n low cycles 2-5, ack1 at cycle 8 with rdata1=16'hBEEF, rdata0 unchanged (0).
REQ-027 Contention: req0=req1=1 continuously from reset -> grants alternate 0,1,0,1, acks every 9 cycles, never simultaneous.
REQ-028 Input change: addr0 changed from 1 to 3 during STROBE -> hpi_address stays 1 for the whole transaction.
REQ-029 Reset at cycle 4 of a write -> at cycle 5 hpi_w_n=1, hpi_cs_n=1, busy=0; no ack0 afterward until a new req0.
REQ-030 Parameters STROBE_CYCLES=1, HOLD_CYCLES=1, RECOVERY_CYCLES=1 -> ack at cycle 4, next grant at cycle 5.

Source files
------------

// File: rtl/hpi_access_seq.sv
// hpi_access_seq: two-requester access sequencer for the HPI register port.
// Picks one requester (alternating on ties), then runs one access through
// setup, strobe, hold and recovery phases and returns a one-cycle ack.
//
// state    | meaning
// IDLE     | waiting for a request; cs and strobes inactive
// SETUP    | cs low, address valid, strobes inactive (1 cycle)
// STROBE   | cs low, w_n (write) or r_n (read) low for STROBE_CYCLES
// HOLD     | cs low, strobes inactive for HOLD_CYCLES; read data sampled at its end
// RECOVER  | cs high for RECOVERY_CYCLES; ack pulses in the first cycle
module hpi_access_seq #(
  parameter int unsigned STROBE_CYCLES   = 4,
  parameter int unsigned HOLD_CYCLES     = 2,
  parameter int unsigned RECOVERY_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_cs_n,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] RECOV_LOAD  = 4'(RECOVERY_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q;      // requester owning the access in flight
  logic        last_q;     // requester granted most recently
  logic        we_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic        ack0_q, ack1_q;
  logic [15:0] rdata0_q, rdata1_q;
  logic        grant;
  logic        grant_sel;
  logic        done;       // last HOLD cycle: the access completes on this edge

  // Next state, phase counter reload/decrement and strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    grant_sel = 1'b0;
    done      = 1'b0;
    hpi_cs_n  = 1'b1;
    hpi_r_n   = 1'b1;
    hpi_w_n   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          grant_sel = (req0 && req1) ? ~last_q : req1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        hpi_cs_n = 1'b0;
        cnt_d    = STROBE_LOAD;
        state_d  = ST_STROBE;
      end
      ST_STROBE: begin
        hpi_cs_n = 1'b0;
        hpi_w_n  = ~we_q;
        hpi_r_n  = we_q;
        if (cnt_q == 4'd0) begin
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        hpi_cs_n = 1'b0;
        if (cnt_q == 4'd0) begin
          done    = 1'b1;
          cnt_d   = RECOV_LOAD;
          state_d = ST_RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and phase counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access latch, arbitration pointer, completion pulse and read-data capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= 2'd0;
      wdata_q  <= 16'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 16'd0;
      rdata1_q <= 16'd0;
    end else begin
      ack0_q <= done & ~gnt_q;
      ack1_q <= done & gnt_q;
      if (grant) begin
        gnt_q   <= grant_sel;
        last_q  <= grant_sel;
        we_q    <= grant_sel ? we1 : we0;
        addr_q  <= grant_sel ? addr1 : addr0;
        wdata_q <= grant_sel ? wdata1 : wdata0;
      end
      if (done && !we_q) begin
        if (gnt_q) begin
          rdata1_q <= hpi_data_in;
        end else begin
          rdata0_q <= hpi_data_in;
        end
      end
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign hpi_address  = addr_q;
  assign hpi_data_out = wdata_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hpi_access_seq.sv
// Bench for hpi_access_seq: a default-parameter instance (A) and a
// STROBE=HOLD=RECOVERY=1 instance (B), each tracked every cycle by an
// access-level model keyed on the cycle count since the grant.
module tb_hpi_access_seq;

  localparam int SA = 4, HA = 2, RA = 1;
  localparam int SB = 1, HB = 1, RB = 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [1:0]  addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0, hpi_data_in = 0;
  logic        ack0, ack1, hpi_r_n, hpi_w_n, hpi_cs_n, busy;
  logic [15:0] rdata0, rdata1, hpi_data_out;
  logic [1:0]  hpi_address;

  logic        req0_f = 0, req1_f = 0, we0_f = 0, we1_f = 0;
  logic [1:0]  addr0_f = 0, addr1_f = 0;
  logic [15:0] wdata0_f = 0, wdata1_f = 0, hpi_data_in_f = 0;
  logic        ack0_f, ack1_f, hpi_r_n_f, hpi_w_n_f, hpi_cs_n_f, busy_f;
  logic [15:0] rdata0_f, rdata1_f, hpi_data_out_f;
  logic [1:0]  hpi_address_f;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  always #5 Clk = ~Clk;

  hpi_access_seq dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .hpi_address(hpi_address), .hpi_data_out(hpi_data_out), .hpi_data_in(hpi_data_in),
    .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_cs_n(hpi_cs_n), .busy(busy)
  );

  hpi_access_seq #(.STROBE_CYCLES(SB), .HOLD_CYCLES(HB), .RECOVERY_CYCLES(RB)) dut_f (
    .Clk(Clk), .Reset(Reset),
    .req0(req0_f), .req1(req1_f), .we0(we0_f), .we1(we1_f),
    .addr0(addr0_f), .addr1(addr1_f), .wdata0(wdata0_f), .wdata1(wdata1_f),
    .ack0(ack0_f), .ack1(ack1_f), .rdata0(rdata0_f), .rdata1(rdata1_f),
    .hpi_address(hpi_address_f), .hpi_data_out(hpi_data_out_f), .hpi_data_in(hpi_data_in_f),
    .hpi_r_n(hpi_r_n_f), .hpi_w_n(hpi_w_n_f), .hpi_cs_n(hpi_cs_n_f), .busy(busy_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Access-level model: k counts cycles since the grant edge (k=1 is the
  // first cycle after it); everything else is arithmetic on k.
  typedef struct {
    bit          act;
    int          k;
    bit          gnt;
    bit          last;
    bit          we;
    logic [1:0]  addr;
    logic [15:0] wd;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(input mdl_t mi, input logic rst, input logic r0, input logic r1,
                                 input logic w0, input logic w1, input logic [1:0] a0,
                                 input logic [1:0] a1, input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] din, input int s, input int h, input int r);
    mdl_t m;
    m = mi;
    if (rst) begin
      m.act = 0; m.k = 0; m.gnt = 0; m.last = 1; m.we = 0;
      m.addr = 0; m.wd = 0; m.rd0 = 0; m.rd1 = 0;
    end else if (!m.act) begin
      if (r0 || r1) begin
        m.gnt  = (r0 && r1) ? !m.last : r1;
        m.last = m.gnt;
        m.we   = m.gnt ? w1 : w0;
        m.addr = m.gnt ? a1 : a0;
        m.wd   = m.gnt ? d1 : d0;
        m.act  = 1;
        m.k    = 1;
      end
    end else begin
      if (m.k == 1 + s + h && !m.we) begin
        if (m.gnt) m.rd1 = din;
        else       m.rd0 = din;
      end
      if (m.k == 1 + s + h + r) m.act = 0;
      else                      m.k++;
    end
    return m;
  endfunction

  task automatic mcheck(input string tag, input mdl_t m, input int s, input int h,
                        input logic a0, input logic a1, input logic [15:0] rd0,
                        input logic [15:0] rd1, input logic [1:0] ad, input logic [15:0] dout,
                        input logic rn, input logic wn, input logic csn, input logic bsy);
    logic cs_e, stb, ack_e;
    cs_e  = m.act && (m.k <= 1 + s + h);
    stb   = m.act && (m.k >= 2) && (m.k <= 1 + s);
    ack_e = m.act && (m.k == 2 + s + h);
    chk({tag, " cs_n"},   32'(csn),  32'(!cs_e));
    chk({tag, " w_n"},    32'(wn),   32'(!(stb && m.we)));
    chk({tag, " r_n"},    32'(rn),   32'(!(stb && !m.we)));
    chk({tag, " busy"},   32'(bsy),  32'(m.act));
    chk({tag, " ack0"},   32'(a0),   32'(ack_e && !m.gnt));
    chk({tag, " ack1"},   32'(a1),   32'(ack_e && m.gnt));
    chk({tag, " rdata0"}, 32'(rd0),  32'(m.rd0));
    chk({tag, " rdata1"}, 32'(rd1),  32'(m.rd1));
    chk({tag, " addr"},   32'(ad),   32'(m.addr));
    chk({tag, " dout"},   32'(dout), 32'(m.wd));
  endtask

  // Advance both models on every rising edge using the inputs the DUTs see.
  always @(posedge Clk) begin
    ma = mstep(ma, Reset, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, hpi_data_in, SA, HA, RA);
    mb = mstep(mb, Reset, req0_f, req1_f, we0_f, we1_f, addr0_f, addr1_f, wdata0_f, wdata1_f,
               hpi_data_in_f, SB, HB, RB);
    if (Reset) chk_en = 1;
  end

  // Compare both DUTs against their models mid-cycle.
  always @(negedge Clk) begin
    if (chk_en) begin
      mcheck("mdlA", ma, SA, HA, ack0, ack1, rdata0, rdata1, hpi_address, hpi_data_out,
             hpi_r_n, hpi_w_n, hpi_cs_n, busy);
      mcheck("mdlB", mb, SB, HB, ack0_f, ack1_f, rdata0_f, rdata1_f, hpi_address_f, hpi_data_out_f,
             hpi_r_n_f, hpi_w_n_f, hpi_cs_n_f, busy_f);
    end
  end

  typedef struct {
    bit          sel;
    bit          we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          exp_lat;
    int          exp_wl;
    int          exp_rl;
    logic [15:0] exp_rd0;
    logic [15:0] exp_rd1;
    logic [1:0]  exp_addr;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    Reset = 1; req0 = 0; req1 = 0; req0_f = 0; req1_f = 0;
    repeat (2) @(negedge Clk);
    Reset = 0;
  endtask

  // One access on instance A, starting from an IDLE negedge.
  task automatic txn_a(input bit sel, input bit we, input logic [1:0] a, input logic [15:0] wd,
                       input logic [15:0] din, output int lat, output int wl, output int rl,
                       output int other);
    lat = -1; wl = 0; rl = 0; other = 0;
    hpi_data_in = din;
    if (sel) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    else     begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    for (int n = 1; n <= 30 && lat < 0; n++) begin
      @(negedge Clk);
      if (!hpi_w_n) wl++;
      if (!hpi_r_n) rl++;
      if (sel ? ack0 : ack1) other++;
      if (sel ? ack1 : ack0) begin
        lat = n; req0 = 0; req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wl, rl, other, cnt;
    int acks_n[$];
    int acks_w[$];
    int exp_n[4];
    int exp_w[4];

    vecs[0] = '{0, 1, 2'd2, 16'h1234, 16'h0000, 8, 4, 0, 16'h0000, 16'h0000, 2'd2, 16'h1234};
    vecs[1] = '{1, 0, 2'd0, 16'h0000, 16'hBEEF, 8, 0, 4, 16'h0000, 16'hBEEF, 2'd0, 16'h0000};
    vecs[2] = '{0, 0, 2'd3, 16'h5555, 16'hCAFE, 8, 0, 4, 16'hCAFE, 16'hBEEF, 2'd3, 16'h5555};
    vecs[3] = '{1, 1, 2'd1, 16'hA5A5, 16'h1111, 8, 4, 0, 16'hCAFE, 16'hBEEF, 2'd1, 16'hA5A5};
    vecs[4] = '{0, 1, 2'd0, 16'h0F0F, 16'h2222, 8, 4, 0, 16'hCAFE, 16'hBEEF, 2'd0, 16'h0F0F};
    vecs[5] = '{1, 0, 2'd2, 16'h7777, 16'h0042, 8, 0, 4, 16'hCAFE, 16'h0042, 2'd2, 16'h7777};
    exp_n = '{8, 17, 26, 35};
    exp_w = '{0, 1, 0, 1};

    repeat (3) @(negedge Clk);
    chk("rst cs_n", 32'(hpi_cs_n), 1);
    chk("rst r_n", 32'(hpi_r_n), 1);
    chk("rst w_n", 32'(hpi_w_n), 1);
    chk("rst addr", 32'(hpi_address), 0);
    chk("rst dout", 32'(hpi_data_out), 0);
    chk("rst ack0", 32'(ack0), 0);
    chk("rst ack1", 32'(ack1), 0);
    chk("rst rdata0", 32'(rdata0), 0);
    chk("rst rdata1", 32'(rdata1), 0);
    chk("rst busy", 32'(busy), 0);
    Reset = 0;
    @(negedge Clk);

    for (int i = 0; i < 6; i++) begin
      txn_a(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].din, lat, wl, rl, other);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d w_n_low", i), 32'(wl), 32'(vecs[i].exp_wl));
      chk($sformatf("vec%0d r_n_low", i), 32'(rl), 32'(vecs[i].exp_rl));
      chk($sformatf("vec%0d other_ack", i), 32'(other), 0);
      chk($sformatf("vec%0d rdata0", i), 32'(rdata0), 32'(vecs[i].exp_rd0));
      chk($sformatf("vec%0d rdata1", i), 32'(rdata1), 32'(vecs[i].exp_rd1));
      chk($sformatf("vec%0d addr", i), 32'(hpi_address), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d dout", i), 32'(hpi_data_out), 32'(vecs[i].exp_dout));
    end

    // Requester inputs change mid-STROBE; the access in flight must not follow.
    req0 = 1; we0 = 1; addr0 = 2'd1; wdata0 = 16'h0101; lat = -1;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      @(negedge Clk);
      if (n == 3) begin addr0 = 2'd3; wdata0 = 16'hFFFF; we0 = 0; end
      if (n <= 8) chk($sformatf("addr_hold c%0d", n), 32'(hpi_address), 1);
      if (ack0) begin lat = n; req0 = 0; end
    end
    req0 = 0;
    chk("addr_hold latency", 32'(lat), 8);
    chk("addr_hold dout", 32'(hpi_data_out), 32'h0101);
    @(negedge Clk);

    // Both requesters held from reset: grants alternate starting with 0.
    Reset = 1; req0 = 1; req1 = 1; we0 = 1; we1 = 0;
    repeat (2) @(negedge Clk);
    Reset = 0;
    for (int n = 1; n <= 36; n++) begin
      @(negedge Clk);
      if (ack0) begin acks_n.push_back(n); acks_w.push_back(0); end
      if (ack1) begin acks_n.push_back(n); acks_w.push_back(1); end
    end
    req0 = 0; req1 = 0;
    chk("contend ack_count", 32'(acks_n.size()), 4);
    if (acks_n.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("contend ack%0d cycle", i), 32'(acks_n[i]), 32'(exp_n[i]));
        chk($sformatf("contend ack%0d who", i), 32'(acks_w[i]), 32'(exp_w[i]));
      end
    end
    do_reset();
    @(negedge Clk);

    // Reset in cycle 4 of a write aborts it without an ack.
    req0 = 1; we0 = 1; addr0 = 2'd1; wdata0 = 16'h3C3C;
    for (int n = 1; n <= 5; n++) begin
      @(negedge Clk);
      if (n == 4) begin
        chk("abort pre w_n", 32'(hpi_w_n), 0);
        Reset = 1; req0 = 0;
      end
      if (n == 5) begin
        chk("abort w_n", 32'(hpi_w_n), 1);
        chk("abort cs_n", 32'(hpi_cs_n), 1);
        chk("abort busy", 32'(busy), 0);
        Reset = 0;
      end
    end
    cnt = 0;
    repeat (20) begin
      @(negedge Clk);
      if (ack0) cnt++;
    end
    chk("abort no_ack0", 32'(cnt), 0);

    // Minimum-parameter instance: ack at 4, re-grant at 5 so next ack at 9.
    acks_n.delete();
    req0_f = 1; we0_f = 1; addr0_f = 2'd1; wdata0_f = 16'h4321;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (n == 6) req0_f = 0;
      if (ack0_f) acks_n.push_back(n);
    end
    chk("fast ack_count", 32'(acks_n.size()), 2);
    if (acks_n.size() == 2) begin
      chk("fast first_ack", 32'(acks_n[0]), 4);
      chk("fast second_ack", 32'(acks_n[1]), 9);
    end

    // Random traffic on both instances, checked by the models.
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      Reset         = ($urandom_range(0, 79) == 0);
      req0          = ($urandom_range(0, 3) != 0);
      req1          = ($urandom_range(0, 3) != 0);
      we0           = 1'($urandom_range(0, 1));
      we1           = 1'($urandom_range(0, 1));
      addr0         = 2'($urandom);
      addr1         = 2'($urandom);
      wdata0        = 16'($urandom);
      wdata1        = 16'($urandom);
      hpi_data_in   = 16'($urandom);
      req0_f        = ($urandom_range(0, 2) == 0);
      req1_f        = ($urandom_range(0, 2) == 0);
      we0_f         = 1'($urandom_range(0, 1));
      we1_f         = 1'($urandom_range(0, 1));
      addr0_f       = 2'($urandom);
      addr1_f       = 2'($urandom);
      wdata0_f      = 16'($urandom);
      wdata1_f      = 16'($urandom);
      hpi_data_in_f = 16'($urandom);
    end
    Reset = 0;
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
